// File: rtl/gps_pps_pkg.sv
// Shared state type and timing constants for the GPS PPS supervisor.
package gps_pps_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2,
        StHoldover = 2'd3
    } pps_state_t;

    localparam int unsigned DefClkHz       = 100_000_000;
    localparam int unsigned DefTol         = 1000;
    localparam int unsigned DefPeriodLo    = DefClkHz - DefTol;
    localparam int unsigned DefPeriodHi    = DefClkHz + DefTol;
    localparam int unsigned AcqTimeoutMult = 4;

    function automatic logic [31:0] period_lo(input int unsigned clk_hz, input int unsigned tol);
        return 32'(clk_hz - tol);
    endfunction

    function automatic logic [31:0] period_hi(input int unsigned clk_hz, input int unsigned tol);
        return 32'(clk_hz + tol);
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser for the raw PPS input followed by a rising-edge detector.
module pps_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/gps_pps_ctrl.sv
// PPS supervisor: qualifies PPS edges, synthesises holdover ticks and schedules
// time-core loads into the quiet gap after each second pulse.
module gps_pps_ctrl
    import gps_pps_pkg::*;
#(
    parameter int unsigned CLK_HZ   = DefClkHz,
    parameter int unsigned TOL      = DefTol,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned HOLD_MAX = 10,
    parameter int unsigned PULSE_W  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pps_in,
    input  logic       load_req,
    output logic       load_ack,
    output logic       gps_wr,
    output logic       pps_to_core,
    output logic [1:0] state,
    output logic       time_valid,
    output logic [7:0] holdover_secs
);

    localparam logic [31:0] PeriodLo    = period_lo(CLK_HZ, TOL);
    localparam logic [31:0] PeriodHi    = period_hi(CLK_HZ, TOL);
    localparam logic [31:0] Nominal     = 32'(CLK_HZ);
    localparam logic [31:0] AcqTimeout  = 32'(AcqTimeoutMult * CLK_HZ);
    localparam logic [31:0] HoldRestart = 32'(TOL);
    localparam logic [7:0]  LockCnt     = 8'(LOCK_CNT);
    localparam logic [7:0]  HoldMax     = 8'(HOLD_MAX);
    localparam logic [15:0] PwInit      = 16'(PULSE_W - 1);

    logic        w_rise;
    logic [31:0] w_cnt_nxt;
    logic        w_good;
    logic [7:0]  w_good_inc;

    pps_state_t  r_state;
    logic        r_time_valid;
    logic [31:0] r_cnt;
    logic [7:0]  r_good_cnt;
    logic [7:0]  r_hold_secs;
    logic        r_pulse;
    logic [15:0] r_pw;
    logic        r_pulse_d;
    logic        r_wr;

    pps_sync_edge u_sync_edge (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (pps_in),
        .o_rise  (w_rise)
    );

    // Decisions use the count including the current cycle, i.e. the period length.
    assign w_cnt_nxt  = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
    assign w_good     = (w_cnt_nxt >= PeriodLo) && (w_cnt_nxt <= PeriodHi);
    assign w_good_inc = r_good_cnt + 8'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_time_valid <= 1'b0;
            r_cnt        <= 32'd0;
            r_good_cnt   <= 8'd0;
            r_hold_secs  <= 8'd0;
            r_pulse      <= 1'b0;
            r_pw         <= 16'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (r_pw != 16'd0) begin
                r_pw <= r_pw - 16'd1;
            end else begin
                r_pulse <= 1'b0;
            end
            // Each tick below overrides the stretcher defaults and restarts the width.
            unique case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        r_state    <= StAcquire;
                        r_good_cnt <= 8'd0;
                        r_cnt      <= 32'd0;
                        r_pulse    <= 1'b1;
                        r_pw       <= PwInit;
                    end
                end
                StAcquire: begin
                    if (w_rise) begin
                        r_cnt   <= 32'd0;
                        r_pulse <= 1'b1;
                        r_pw    <= PwInit;
                        if (w_good) begin
                            r_good_cnt <= w_good_inc;
                            if (w_good_inc >= LockCnt) begin
                                r_state      <= StLocked;
                                r_time_valid <= 1'b1;
                            end
                        end else begin
                            r_good_cnt <= 8'd0;
                        end
                    end else if (w_cnt_nxt >= AcqTimeout) begin
                        r_state <= StIdle;
                    end
                end
                StLocked: begin
                    if (w_rise && w_good) begin
                        r_cnt   <= 32'd0;
                        r_pulse <= 1'b1;
                        r_pw    <= PwInit;
                    end else if (w_cnt_nxt >= PeriodHi) begin
                        // Restarting at TOL keeps synthetic ticks on the nominal grid.
                        r_state     <= StHoldover;
                        r_cnt       <= HoldRestart;
                        r_hold_secs <= 8'd0;
                        r_pulse     <= 1'b1;
                        r_pw        <= PwInit;
                    end
                end
                StHoldover: begin
                    if (w_rise) begin
                        r_state      <= StAcquire;
                        r_time_valid <= 1'b0;
                        r_good_cnt   <= 8'd0;
                        r_hold_secs  <= 8'd0;
                        r_cnt        <= 32'd0;
                        r_pulse      <= 1'b1;
                        r_pw         <= PwInit;
                    end else if (w_cnt_nxt >= Nominal) begin
                        if (r_hold_secs >= HoldMax) begin
                            r_state      <= StIdle;
                            r_time_valid <= 1'b0;
                        end else begin
                            r_cnt   <= 32'd0;
                            r_pulse <= 1'b1;
                            r_pw    <= PwInit;
                            if (r_hold_secs != 8'hFF) begin
                                r_hold_secs <= r_hold_secs + 8'd1;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Load fires in the cycle right after the pulse falls, while the core's edge logic is idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pulse_d <= 1'b0;
            r_wr      <= 1'b0;
        end else begin
            r_pulse_d <= r_pulse;
            r_wr      <= load_req && r_time_valid && r_pulse_d && !r_pulse;
        end
    end

    assign pps_to_core   = r_pulse;
    assign gps_wr        = r_wr;
    assign load_ack      = r_wr;
    assign state         = r_state;
    assign time_valid    = r_time_valid;
    assign holdover_secs = r_hold_secs;

endmodule

// File: doc/gps_pps_ctrl.md
# gps_pps_ctrl

PPS supervisor and time-load sequencer that sits in front of the GPS time-of-day counter core. It synchronises and qualifies the raw `pps_in`, then drives the core's second-tick input (`pps_to_core`) and its load strobe (`gps_wr`). While PPS is good it forwards qualified edges. When PPS is lost it synthesises ticks (holdover). It schedules software time loads so they land exactly between second ticks.

## Interface
- `CLK_HZ`, 100_000_000: nominal clock cycles per PPS period.
- `TOL`, 1000: accepted period deviation, ±cycles.
- `LOCK_CNT`, 3: consecutive good periods required to lock.
- `HOLD_MAX`, 10: maximum synthesised seconds before dropping to IDLE.
- `PULSE_W`, 16: `pps_to_core` high width in cycles.

Ports:
- `clk` input 1: single clock.
- `resetn` input 1: reset is asynchronous and active-low.
- `pps_in` input 1: raw PPS from receiver, asynchronous.
- `load_req` input 1: software requests time load; held high until `load_ack`.
- `load_ack` output 1: one-cycle acknowledge, coincident with `gps_wr`.
- `gps_wr` output 1: one-cycle load strobe to the time core.
- `pps_to_core` output 1: qualified or synthetic PPS pulse to the core.
- `state` output 2: 0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER.
- `time_valid` output 1: high in LOCKED or HOLDOVER.
- `holdover_secs` output 8: synthesised ticks since entering HOLDOVER, saturating at 255.

## Operation
- Edge detection: `pps_in` passes through a 2-flop synchroniser, then a rising-edge detector.
- Period counter: 32-bit, saturating, counts cycles since the last accepted edge. It restarts to 0 on an accepted edge or a synthetic tick.
- A period is good when it lies within CLK_HZ−TOL to CLK_HZ+TOL inclusive.

State machine:
- **IDLE**: no ticks are issued. The first edge moves to ACQUIRE with `good_cnt` = 0 and restarts the counter.
- **ACQUIRE**:
  - Every edge is forwarded as a tick.
  - A good-period edge increments `good_cnt`. When `good_cnt` reaches LOCK_CNT, go to LOCKED.
  - A bad-period edge sets `good_cnt` to 0 and restarts the counter.
  - If the counter reaches 4·CLK_HZ, return to IDLE.
- **LOCKED**:
  - A good edge is forwarded and restarts the counter.
  - An edge with period < CLK_HZ−TOL is a glitch: it is ignored, with no tick and no restart.
  - When the counter reaches CLK_HZ+TOL without an edge, go to HOLDOVER. On that same cycle, issue a synthetic tick and restart the counter at TOL, so the next synthetic tick falls CLK_HZ after the nominal position.
- **HOLDOVER**:
  - A synthetic tick is issued each time the counter reaches CLK_HZ; `holdover_secs` increments on each one.
  - Any real edge goes to ACQUIRE with `good_cnt` = 0. That edge is forwarded and `holdover_secs` clears.
  - When `holdover_secs` reaches HOLD_MAX, go to IDLE on the next would-be tick instead of issuing it.

Tick output and load sequencing:
- A tick drives `pps_to_core` high for PULSE_W cycles. A new tick during an active pulse restarts the width count.
- `load_req` is accepted only when `time_valid` = 1; otherwise it stays pending.
- A pending request fires `gps_wr` and `load_ack` for one cycle on the first cycle after `pps_to_core` falls. This guarantees the core's own edge detector is idle when it reloads.
- Software places the current second in the init registers and drops `load_req` after `load_ack`. A `load_req` that is still high one cycle after ack is a new request.
- If `load_req` falls before ack, the request is withdrawn.
- On an asynchronous reset at any point, all state clears immediately and any pending load is dropped.

## Timing
- Reset values: `state` = 0, every other output 0, all internal counters 0, synchroniser flops 0.
- Latency from `pps_in` rising (sampled) to `pps_to_core` rising: 3 cycles (2 sync + 1 edge/decision).
- `state` and `time_valid` update on the same cycle as the tick decision.
- `gps_wr` occurs PULSE_W+1 cycles after `pps_to_core` rises, at the earliest.
- A glitch edge and a holdover timeout on the same cycle: the timeout wins.

## Structure
- Package `gps_pps_pkg`:
  - state enum `pps_state_t`
  - localparams for the period bounds CLK_HZ±TOL
  - constant for the ACQUIRE timeout multiple (4)
- Sub-module `pps_sync_edge`: 2-flop synchroniser plus rising-edge detector, 1-cycle pulse out.
- The top level holds the FSM, the period counter, the pulse stretcher and the load scheduler.

## Test plan
Bench parameters: CLK_HZ=1000, TOL=10, LOCK_CNT=3, HOLD_MAX=4, PULSE_W=4.

- **Lock**: 5 pulses at 1000-cycle spacing → `state` goes to ACQUIRE after edge 1 and LOCKED after edge 4; 5 `pps_to_core` pulses of 4 cycles each, each rising 3 cycles after its `pps_in` edge.
- **Glitch**: while LOCKED, an extra edge 300 cycles after a good edge → no tick, `state` stays LOCKED, and the next edge at 1000 is accepted.
- **Holdover**:
  - Stop PPS while LOCKED → HOLDOVER at 1010 cycles with a tick.
  - Further ticks every 1000 cycles, `holdover_secs` counting 1..4.
  - Then IDLE, `time_valid` = 0.
- **Re-acquire**: PPS resumes during HOLDOVER → ACQUIRE on the first edge, with the tick forwarded and `holdover_secs` = 0.
- **Load**: while LOCKED, assert `load_req` mid-second → `gps_wr` and `load_ack` each one cycle, exactly 1 cycle after the next `pps_to_core` falls. `load_req` asserted in IDLE → no ack until locked.
- **Reset**: assert `resetn` = 0 mid-pulse with a load pending → all outputs go to 0 immediately; no `gps_wr` follows after release.
